img_wr_seq: RTL

- Image-write sequencer driving the sequencer write port of the layer image interface (seq_we/seq_row/seq_col/seq_wdata).
- Accepts a raster-ordered pixel stream over a valid/ready handshake and issues exactly one write per accepted pixel, generating row/col addresses.
- Signals frame completion to the EPU controller.
- Supports a hold input so upstream control can pause writes without losing data.

---
 rtl/img_wr_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/img_wr_seq.sv
// img_wr_seq: image-write sequencer.
// Takes a raster-ordered pixel stream over valid/ready and issues one write
// per accepted pixel on the seq_* port, generating row/col addresses.
// It pulses frame_done together with the write of the final pixel.
// Optional build macro IMGWR_SYNC_CHK_EN adds SOF/EOL marker checking on
// err_sync. Without it, err_sync is tied to 0.
module img_wr_seq #(
    parameter int IMG_H  = 255,
    parameter int IMG_W  = 255,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic              seq_we,
    output logic [15:0]       seq_row,
    output logic [15:0]       seq_col,
    output logic [DATA_W-1:0] seq_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              err_sync
);

    // Counters are at least one bit wide so that 1-row or 1-column images stay legal.
    // Images are assumed to fit the 16-bit address bus.
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic              r_we;
    logic [15:0]       r_seq_row;
    logic [15:0]       r_seq_col;
    logic [DATA_W-1:0] r_wdata;

    logic w_in_ready;
    logic w_accept;
    logic w_row_last;
    logic w_col_last;
    logic w_arm;

    assign w_in_ready = (r_state == S_RUN) && !hold;
    assign w_accept   = in_valid && w_in_ready;
    assign w_row_last = (r_row == ROW_LAST);
    assign w_col_last = (r_col == COL_LAST);
    assign w_arm      = (r_state == S_IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: DONE lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && w_row_last && w_col_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Raster address counters: cleared on arm, advanced once per accepted pixel.
    always_ff @(posedge clk) begin
        if (rst || w_arm) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Registered write port: one write the cycle after each accept.
    // Address and data hold their last values between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_seq_row <= '0;
            r_seq_col <= '0;
            r_wdata   <= '0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_seq_row <= 16'(r_row);
                r_seq_col <= 16'(r_col);
                r_wdata   <= in_data;
            end
        end
    end

`ifdef IMGWR_SYNC_CHK_EN
    logic r_err_sync;
    logic w_first_pix;

    assign w_first_pix = (r_row == '0) && (r_col == '0);

    // Sticky marker check. It only flags errors and never resynchronizes the counters.
    always_ff @(posedge clk) begin
        if (rst || w_arm) begin
            r_err_sync <= 1'b0;
        end else if (w_accept && ((in_sof != w_first_pix) || (in_eol != w_col_last))) begin
            r_err_sync <= 1'b1;
        end
    end

    assign err_sync = r_err_sync;
`else
    // The markers are ignored in this build.
    logic w_unused_markers;
    assign w_unused_markers = in_sof ^ in_eol;
    assign err_sync         = 1'b0;
`endif

    assign in_ready   = w_in_ready;
    assign seq_we     = r_we;
    assign seq_row    = r_seq_row;
    assign seq_col    = r_seq_col;
    assign seq_wdata  = r_wdata;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);

endmodule
